// File: rtl/mem_wait_ctrl.sv
// Memory wait-state controller behind the 4510 mapper: region decode, registered chip selects,
// per-region wait states, and single-master DMA arbitration. Define WS_PROG_EN for programmable wait states.
module mem_wait_ctrl #(
  parameter logic [19:0] ROM_BASE = 20'h20000,
  parameter logic [19:0] IO_BASE  = 20'hD0000,
  parameter int unsigned RAM_WS   = 0,
  parameter int unsigned ROM_WS   = 1,
  parameter int unsigned IO_WS    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
`ifdef WS_PROG_EN
  input  logic        cfg_we,
  input  logic [1:0]  cfg_sel,
  input  logic [2:0]  cfg_data,
`endif
  input  logic [19:0] address_next,
  input  logic        map_next,
  input  logic        we_next,
  input  logic        ext_wait,
  input  logic        dma_req,
  output logic        ready,
  output logic [19:0] mem_addr,
  output logic        mem_we,
  output logic        mem_map,
  output logic        cs_ram,
  output logic        cs_rom,
  output logic        cs_io,
  output logic        dma_gnt
);

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_DMA, ST_REL} state_e;

  // Chip-select bit positions inside cs_q.
  localparam int CS_RAM = 0;
  localparam int CS_ROM = 1;
  localparam int CS_IO  = 2;

  state_e      state_q, state_d;
  logic [2:0]  wcnt_q, wcnt_d;
  logic        ready_q, ready_d;
  logic [19:0] mem_addr_q, mem_addr_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_map_q, mem_map_d;
  logic [2:0]  cs_q, cs_d;
  logic        dma_gnt_q, dma_gnt_d;

  logic [2:0]  ws_ram, ws_rom, ws_io;

`ifdef WS_PROG_EN
  logic [2:0] ws_ram_q, ws_ram_d;
  logic [2:0] ws_rom_q, ws_rom_d;
  logic [2:0] ws_io_q, ws_io_d;

  always_comb begin
    ws_ram_d = ws_ram_q;
    ws_rom_d = ws_rom_q;
    ws_io_d  = ws_io_q;
    if (cfg_we) begin
      case (cfg_sel)
        2'd0:    ws_ram_d = cfg_data;
        2'd1:    ws_rom_d = cfg_data;
        2'd2:    ws_io_d  = cfg_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ws_ram_q <= 3'(RAM_WS);
      ws_rom_q <= 3'(ROM_WS);
      ws_io_q  <= 3'(IO_WS);
    end else begin
      ws_ram_q <= ws_ram_d;
      ws_rom_q <= ws_rom_d;
      ws_io_q  <= ws_io_d;
    end
  end

  assign ws_ram = ws_ram_q;
  assign ws_rom = ws_rom_q;
  assign ws_io  = ws_io_q;
`else
  assign ws_ram = 3'(RAM_WS);
  assign ws_rom = 3'(ROM_WS);
  assign ws_io  = 3'(IO_WS);
`endif

  logic [2:0] cs_dec;
  logic [2:0] ws_dec;

  // Unsigned full-width compares: each region is inclusive at its base, exclusive at the next base.
  always_comb begin
    cs_dec = '0;
    ws_dec = ws_ram;
    if (address_next < ROM_BASE) begin
      cs_dec[CS_RAM] = 1'b1;
      ws_dec         = ws_ram;
    end else if (address_next < IO_BASE) begin
      cs_dec[CS_ROM] = 1'b1;
      ws_dec         = ws_rom;
    end else begin
      cs_dec[CS_IO]  = 1'b1;
      ws_dec         = ws_io;
    end
  end

  // NOTE: every _d gets its hold value first so no path through this block can infer a latch.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    ready_d    = ready_q;
    mem_addr_d = mem_addr_q;
    mem_we_d   = mem_we_q;
    mem_map_d  = mem_map_q;
    cs_d       = cs_q;
    dma_gnt_d  = dma_gnt_q;

    case (state_q)
      ST_RUN: begin
        if (dma_req) begin
          // A pending DMA request wins the cycle boundary; no access is latched.
          ready_d   = 1'b0;
          dma_gnt_d = 1'b1;
          cs_d      = '0;
          mem_we_d  = 1'b0;
          state_d   = ST_DMA;
        end else begin
          mem_addr_d = address_next;
          mem_we_d   = we_next;
          mem_map_d  = map_next;
          cs_d       = cs_dec;
          wcnt_d     = ws_dec;
          if (ws_dec == 3'd0) begin
            ready_d = 1'b1;
          end else begin
            ready_d = 1'b0;
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (wcnt_q > 3'd1) begin
          wcnt_d = wcnt_q - 3'd1;
        end else if (cs_q[CS_IO] && ext_wait) begin
          wcnt_d = 3'd0;
        end else begin
          wcnt_d  = 3'd0;
          ready_d = 1'b1;
          state_d = ST_RUN;
        end
      end

      ST_DMA: begin
        if (!dma_req) begin
          dma_gnt_d = 1'b0;
          state_d   = ST_REL;
        end
      end

      ST_REL: begin
        ready_d = 1'b1;
        state_d = ST_RUN;
      end

      default: begin
        state_d = ST_RUN;
        ready_d = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_RUN;
      wcnt_q     <= 3'd0;
      ready_q    <= 1'b1;
      mem_addr_q <= 20'd0;
      mem_we_q   <= 1'b0;
      mem_map_q  <= 1'b0;
      cs_q       <= '0;
      dma_gnt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      ready_q    <= ready_d;
      mem_addr_q <= mem_addr_d;
      mem_we_q   <= mem_we_d;
      mem_map_q  <= mem_map_d;
      cs_q       <= cs_d;
      dma_gnt_q  <= dma_gnt_d;
    end
  end

  assign ready    = ready_q;
  assign mem_addr = mem_addr_q;
  assign mem_we   = mem_we_q;
  assign mem_map  = mem_map_q;
  assign cs_ram   = cs_q[CS_RAM];
  assign cs_rom   = cs_q[CS_ROM];
  assign cs_io    = cs_q[CS_IO];
  assign dma_gnt  = dma_gnt_q;

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// Directed bench for mem_wait_ctrl: decode boundaries, wait-state timing, ext_wait, DMA and reset.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_wait_ctrl;

  logic        clk;
  logic        reset_n;
  logic [19:0] address_next;
  logic        map_next;
  logic        we_next;
  logic        ext_wait;
  logic        dma_req;
  logic        ready;
  logic [19:0] mem_addr;
  logic        mem_we;
  logic        mem_map;
  logic        cs_ram, cs_rom, cs_io;
  logic        dma_gnt;
`ifdef WS_PROG_EN
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [2:0]  cfg_data;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  mem_wait_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
`ifdef WS_PROG_EN
    .cfg_we       (cfg_we),
    .cfg_sel      (cfg_sel),
    .cfg_data     (cfg_data),
`endif
    .address_next (address_next),
    .map_next     (map_next),
    .we_next      (we_next),
    .ext_wait     (ext_wait),
    .dma_req      (dma_req),
    .ready        (ready),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_map      (mem_map),
    .cs_ram       (cs_ram),
    .cs_rom       (cs_rom),
    .cs_io        (cs_io),
    .dma_gnt      (dma_gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Presents one access, checks the latched address/select, then counts clocks with ready low.
  task automatic access(input string tag, input logic [19:0] a, input logic w,
                        input logic [2:0] exp_cs, input int exp_low);
    int low;
    address_next = a;
    we_next      = w;
    map_next     = a[0];
    @(negedge clk);
    check({tag, "_addr"}, 32'(mem_addr), 32'(a));
    check({tag, "_cs"}, 32'({cs_io, cs_rom, cs_ram}), 32'(exp_cs));
    check({tag, "_we"}, 32'(mem_we), 32'(w));
    low = 0;
    while (!ready && low < 20) begin
      low++;
      @(negedge clk);
    end
    check({tag, "_low"}, 32'(low), 32'(exp_low));
  endtask

  logic [3:0] rom_pattern;

  initial begin
    reset_n      = 1'b0;
    address_next = 20'd0;
    map_next     = 1'b0;
    we_next      = 1'b0;
    ext_wait     = 1'b0;
    dma_req      = 1'b0;
`ifdef WS_PROG_EN
    cfg_we   = 1'b0;
    cfg_sel  = 2'd0;
    cfg_data = 3'd0;
`endif
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_gnt", 32'(dma_gnt), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_cs", 32'({cs_io, cs_rom, cs_ram}), 32'd0);
    check("rst_we_map", 32'({mem_we, mem_map}), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Region decode and wait-state length, including both sides of each boundary.
    access("ram", 20'h01234, 1'b1, 3'b001, 0);
    check("ram_map", 32'(mem_map), 32'd0);
    access("ram_top", 20'h1FFFF, 1'b0, 3'b001, 0);
    check("ram_top_map", 32'(mem_map), 32'd1);
    access("rom_base", 20'h20000, 1'b0, 3'b010, 1);
    access("rom_top", 20'hCFFFF, 1'b1, 3'b010, 1);
    access("io_base", 20'hD0000, 1'b0, 3'b100, 2);
    access("io_top", 20'hFFFFF, 1'b0, 3'b100, 2);

    // Holding a ROM address gives back-to-back accesses: ready 0,1,0,1.
    access("rom_b2b", 20'h20000, 1'b0, 3'b010, 1);
    rom_pattern = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("rom_b2b_rdy%0d", i), 32'(ready), 32'(rom_pattern[i]));
    end

    // ext_wait has no effect on ROM.
    ext_wait = 1'b1;
    access("rom_extw", 20'h30000, 1'b0, 3'b010, 1);
    ext_wait = 1'b0;

    // IO with ext_wait: stretched to 5 low clocks, completes the clock after ext_wait falls.
    address_next = 20'hD0010;
    we_next      = 1'b0;
    @(negedge clk);
    check("io_ext_cs", 32'(cs_io), 32'd1);
    check("io_ext_rdy1", 32'(ready), 32'd0);
    ext_wait = 1'b1;
    repeat (4) @(negedge clk);
    check("io_ext_rdy5", 32'(ready), 32'd0);
    ext_wait     = 1'b0;
    address_next = 20'h00000;
    @(negedge clk);
    check("io_ext_done", 32'(ready), 32'd1);
    @(negedge clk);

    // DMA requested mid IO wait: granted only after the IO cycle ends; no latch during DMA/REL.
    address_next = 20'hD0010;
    we_next      = 1'b1;
    @(negedge clk);
    check("dma_io_rdy1", 32'(ready), 32'd0);
    dma_req = 1'b1;
    @(negedge clk);
    check("dma_wait_gnt", 32'({dma_gnt, ready}), 32'b00);
    @(negedge clk);
    check("dma_boundary", 32'({dma_gnt, ready}), 32'b01);
    address_next = 20'h00055;
    we_next      = 1'b0;
    @(negedge clk);
    check("dma_gnt_on", 32'({dma_gnt, ready}), 32'b10);
    check("dma_cs", 32'({cs_io, cs_rom, cs_ram}), 32'd0);
    check("dma_we", 32'(mem_we), 32'd0);
    check("dma_nolatch", 32'(mem_addr), 32'hD0010);
    @(negedge clk);
    check("dma_hold", 32'({dma_gnt, ready}), 32'b10);
    @(negedge clk);
    dma_req = 1'b0;
    @(negedge clk);
    check("dma_rel", 32'({dma_gnt, ready}), 32'b00);
    check("dma_rel_addr", 32'(mem_addr), 32'hD0010);
    @(negedge clk);
    check("dma_done", 32'({dma_gnt, ready}), 32'b01);
    check("dma_done_cs", 32'({cs_io, cs_rom, cs_ram}), 32'd0);
    @(negedge clk);
    check("post_dma_ram", 32'(mem_addr), 32'h00055);

    // Asynchronous reset between edges in the middle of a WAIT.
    address_next = 20'hD0010;
    @(negedge clk);
    check("rst_mid_pre", 32'({cs_io, ready}), 32'b10);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_rdy", 32'(ready), 32'd1);
    check("rst_mid_cs", 32'({cs_io, cs_rom, cs_ram}), 32'd0);
    check("rst_mid_gnt", 32'(dma_gnt), 32'd0);
    address_next = 20'h00000;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

`ifdef WS_PROG_EN
    // Programming 3 RAM wait states applies to the next latched RAM access.
    cfg_we   = 1'b1;
    cfg_sel  = 2'd0;
    cfg_data = 3'd3;
    @(negedge clk);
    cfg_we = 1'b0;
    access("cfg_ram", 20'h00010, 1'b0, 3'b001, 3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
